native_mem_arbiter: RTL and testbench

Shares one single-port 32-bit block RAM and an 8-bit LED register between two requesters. Both requesters use the picorv32 native memory handshake. Master 0 is the CPU; master 1 is a loader/debug port. The block sits between the requesters and the BRAM instance. It performs address decode, round-robin arbitration and the 1-cycle BRAM read-latency sequencing.

---
 rtl/native_mem_arbiter_if.sv | 13 +
 rtl/native_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_native_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/native_mem_arbiter_if.sv
// picorv32-style native memory handshake between one requester and the arbiter.
// The requester drives valid/addr/wdata/wstrb; the arbiter answers with ready/rdata.
interface native_mem_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/native_mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM and an LED register between two
// native-handshake masters, with a fixed 4-cycle IDLE/ISSUE/CAPTURE/RESP sequence.
module native_mem_arbiter #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] LED_ADDR  = 32'h0000_1000,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    native_mem_arbiter_if.slave         m0,
    native_mem_arbiter_if.slave         m1,
    output logic                        mem_en,
    output logic [3:0]                  mem_we,
    output logic [7:0]                  mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    output logic [7:0]                  led,
    output logic                        bus_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_LED, SEL_NONE} sel_t;

    state_t      state;
    state_t      state_next;
    sel_t        sel;
    sel_t        req_sel;
    logic        gnt;
    logic        last;
    logic        pick;
    logic        req_any;
    logic [29:0] req_word;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  led_wdata;
    logic [3:0]  wstrb_q;
    logic [31:0] cap_data;

    // Arbitration and address decode of the master that would win this IDLE cycle.
    always_comb begin
        state_next = state;
        req_any    = m0.valid || m1.valid;
        pick       = (m0.valid && m1.valid) ? ~last : m1.valid;
        req_word   = pick ? m1.addr[31:2] : m0.addr[31:2];
        req_wdata  = pick ? m1.wdata : m0.wdata;
        req_wstrb  = pick ? m1.wstrb : m0.wstrb;
        if (req_word[29:8] == 22'b0 && 32'(req_word[7:0]) < MEM_WORDS)
            req_sel = SEL_RAM;
        else if (req_word == LED_ADDR[31:2])
            req_sel = SEL_LED;
        else
            req_sel = SEL_NONE;
        case (sel)
            SEL_RAM: cap_data = mem_rdata;
            SEL_LED: cap_data = {24'b0, led};
            default: cap_data = ERR_RDATA;
        endcase
        case (state)
            IDLE:    if (req_any) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= 1'b0;
            last      <= 1'b1;
            sel       <= SEL_NONE;
            led_wdata <= 8'h00;
            wstrb_q   <= 4'h0;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            mem_addr  <= 8'h00;
            mem_wdata <= 32'h0;
            led       <= 8'h00;
            bus_err   <= 1'b0;
            m0.ready  <= 1'b0;
            m1.ready  <= 1'b0;
            m0.rdata  <= 32'h0;
            m1.rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt       <= pick;
                        sel       <= req_sel;
                        led_wdata <= req_wdata[7:0];
                        wstrb_q   <= req_wstrb;
                        if (req_sel == SEL_RAM) begin
                            mem_en    <= 1'b1;
                            mem_we    <= req_wstrb;
                            mem_addr  <= req_word[7:0];
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 4'h0;
                    if (sel == SEL_LED && wstrb_q[0])
                        led <= led_wdata;
                end
                CAPTURE: begin
                    // Writes leave the requester's rdata untouched.
                    if (wstrb_q == 4'h0) begin
                        if (gnt)
                            m1.rdata <= cap_data;
                        else
                            m0.rdata <= cap_data;
                    end
                    if (gnt)
                        m1.ready <= 1'b1;
                    else
                        m0.ready <= 1'b1;
                    bus_err <= (sel == SEL_NONE);
                    last    <= gnt;
                end
                RESP: begin
                    m0.ready <= 1'b0;
                    m1.ready <= 1'b0;
                    bus_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_native_mem_arbiter.sv
// Self-checking bench: behavioural BRAM, abstract reference model of memory/LED/fairness,
// directed scenarios followed by randomized single and tied requests.
module tb_native_mem_arbiter;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] LED_ADDR  = 32'h0000_1000;
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  led;
    logic        bus_err;

    int tests = 0;
    int failures = 0;

    native_mem_arbiter_if m0 ();
    native_mem_arbiter_if m1 ();

    native_mem_arbiter #(
        .MEM_WORDS(MEM_WORDS),
        .LED_ADDR (LED_ADDR),
        .ERR_RDATA(ERR_RDATA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0),
        .m1       (m1),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .led      (led),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2)
            return 32'h1234_5678;
        return 32'(i) * 32'h9E37_79B9 + 32'h0F1E_2D3C;
    endfunction

    // Behavioural read-first BRAM with one cycle of read latency.
    logic [31:0] bram [MEM_WORDS];
    always @(posedge clk) begin
        logic [31:0] w;
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++)
                bram[i] <= init_word(i);
        end else if (mem_en) begin
            w = bram[mem_addr];
            mem_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            bram[mem_addr] <= w;
        end
    end

    logic [31:0] ref_mem [MEM_WORDS];
    logic [7:0]  ref_led;
    logic [31:0] ref_rdata [2];
    int          ref_last;

    task automatic ref_reset();
        ref_led      = 8'h00;
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        ref_last     = 1;
    endtask

    task automatic model_access(input int m, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd,
                                output logic err, output logic ram);
        logic led_hit;
        ram     = (a[31:10] == 22'b0) && (32'(a[9:2]) < MEM_WORDS);
        led_hit = !ram && (a[31:2] == LED_ADDR[31:2]);
        err     = !ram && !led_hit;
        if (s != 4'h0) begin
            if (ram) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            end else if (led_hit && s[0]) begin
                ref_led = d[7:0];
            end
        end else begin
            ref_rdata[m] = ram ? ref_mem[a[9:2]] : (led_hit ? {24'b0, ref_led} : ERR_RDATA);
        end
        rd       = ref_rdata[m];
        ref_last = m;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0.valid = v; m0.addr = a; m0.wdata = d; m0.wstrb = s;
        end else begin
            m1.valid = v; m1.addr = a; m1.wdata = d; m1.wstrb = s;
        end
    endtask

    // Waits (bounded) for the next ready pulse and checks it against the model.
    task automatic wait_ready(input int m, input int lat, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        int          cyc = 0;
        int          en_cycles = 0;
        logic [3:0]  we_seen = 4'h0;
        logic [7:0]  addr_seen = 8'h00;
        logic        seen = 1'b0;
        logic        both = 1'b0;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        is_ram;
        while (!seen && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (mem_en) begin
                en_cycles++;
                we_seen   = mem_we;
                addr_seen = mem_addr;
            end
            if (m0.ready && m1.ready) both = 1'b1;
            if (m0.ready || m1.ready) seen = 1'b1;
        end
        model_access(m, a, d, s, exp_rd, exp_err, is_ram);
        check_output("ready_seen", seen, 1'b1);
        check_output("latency", cyc, lat);
        check_output("ready_pair", {m1.ready, m0.ready}, (m == 0) ? 2'b01 : 2'b10);
        check_output("both_ready", both, 1'b0);
        check_output("rdata", (m == 0) ? m0.rdata : m1.rdata, exp_rd);
        check_output("bus_err", bus_err, exp_err);
        check_output("mem_en_cycles", en_cycles, is_ram ? 1 : 0);
        if (is_ram) begin
            check_output("mem_addr", addr_seen, a[9:2]);
            check_output("mem_we", we_seen, s);
        end
        check_output("led", led, ref_led);
        drive(m, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic apply_stimulus(input int m, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
        @(negedge clk);
        drive(m, 1'b1, a, d, s);
        wait_ready(m, 3, a, d, s);
    endtask

    task automatic apply_tie(input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                             input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        int first;
        @(negedge clk);
        drive(0, 1'b1, a0, d0, s0);
        drive(1, 1'b1, a1, d1, s1);
        first = (ref_last == 0) ? 1 : 0;
        if (first == 0) begin
            wait_ready(0, 3, a0, d0, s0);
            wait_ready(1, 4, a1, d1, s1);
        end else begin
            wait_ready(1, 3, a1, d1, s1);
            wait_ready(0, 4, a0, d0, s0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 3))
            0, 1:    return {26'b0, r[3:0], r[5:4]};
            2:       return LED_ADDR | {30'b0, r[1:0]};
            default: return r[0] ? (32'h0000_2000 | {20'b0, r[11:0]}) : (r | 32'h8000_0000);
        endcase
    endfunction

    function automatic logic [3:0] rand_strb();
        if ($urandom_range(0, 1) == 0)
            return 4'h0;
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  s0, s1;
        int          stray;

        reset   = 1'b1;
        preload = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++)
            ref_mem[i] = init_word(i);
        ref_reset();

        check_output("reset_m0_ready", m0.ready, 1'b0);
        check_output("reset_m1_ready", m1.ready, 1'b0);
        check_output("reset_m0_rdata", m0.rdata, 32'h0);
        check_output("reset_m1_rdata", m1.rdata, 32'h0);
        check_output("reset_mem_en", mem_en, 1'b0);
        check_output("reset_mem_we", mem_we, 4'h0);
        check_output("reset_mem_addr", mem_addr, 8'h00);
        check_output("reset_mem_wdata", mem_wdata, 32'h0);
        check_output("reset_led", led, 8'h00);
        check_output("reset_bus_err", bus_err, 1'b0);

        apply_stimulus(0, 32'h0000_0008, 32'h0, 4'h0);
        check_output("bram_read_word2", m0.rdata, 32'h1234_5678);

        apply_stimulus(1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0100);
        apply_stimulus(1, 32'h0000_0004, 32'h0, 4'h0);
        check_output("byte_write_merge", m1.rdata,
                     (init_word(1) & 32'hFF00_FFFF) | 32'h00BB_0000);

        apply_tie(32'h10, 32'h0, 4'h0, 32'h14, 32'h0, 4'h0);
        apply_tie(32'h18, 32'h0, 4'h0, 32'h1C, 32'h0, 4'h0);
        apply_stimulus(1, 32'h20, 32'h0, 4'h0);
        apply_tie(32'h24, 32'h0, 4'h0, 32'h28, 32'h0, 4'h0);

        apply_stimulus(0, LED_ADDR, 32'h0000_00A5, 4'b0001);
        check_output("led_written", led, 8'hA5);
        apply_stimulus(0, LED_ADDR, 32'h0, 4'h0);
        check_output("led_readback", m0.rdata, 32'h0000_00A5);

        apply_stimulus(0, 32'h0000_2000, 32'h0, 4'h0);
        check_output("unmapped_rdata", m0.rdata, ERR_RDATA);
        apply_stimulus(1, 32'h0000_3000, 32'hFFFF_FFFF, 4'hF);
        check_output("unmapped_write_led", led, 8'hA5);
        apply_stimulus(1, 32'h0000_0000, 32'h0, 4'h0);

        for (int it = 0; it < 40; it++) begin
            a0 = rand_addr(); d0 = $urandom; s0 = rand_strb();
            a1 = rand_addr(); d1 = $urandom; s1 = rand_strb();
            case ($urandom_range(0, 2))
                0:       apply_stimulus(0, a0, d0, s0);
                1:       apply_stimulus(1, a1, d1, s1);
                default: apply_tie(a0, d0, s0, a1, d1, s1);
            endcase
        end

        // Abandon a read while it sits in CAPTURE.
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0008, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        ref_reset();
        check_output("midop_m0_ready", m0.ready, 1'b0);
        check_output("midop_m0_rdata", m0.rdata, 32'h0);
        check_output("midop_m1_rdata", m1.rdata, 32'h0);
        check_output("midop_mem_en", mem_en, 1'b0);
        check_output("midop_mem_addr", mem_addr, 8'h00);
        check_output("midop_led", led, 8'h00);
        check_output("midop_bus_err", bus_err, 1'b0);
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (m0.ready || m1.ready || mem_en) stray++;
        end
        check_output("midop_no_ready", stray, 0);
        apply_tie(32'h30, 32'h0, 4'h0, 32'h34, 32'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
